// File: rtl/shift_engine_if.sv
// -----------------------------------------------------------------------------
// shift_engine_if
//   Operand/result bundle between an operand source and the shift_engine.
//
//   start  source -> engine  request, honoured only while busy=0
//   din    source -> engine  WIDTH-bit operand
//   amt    source -> engine  shift amount (0..WIDTH and beyond; clamped/wrapped)
//   mode   source -> engine  0=LSL 1=LSR 2=ASR 3=ROL 4=ROR, 5-7 invalid
//   busy   engine -> source  operation in flight
//   done   engine -> source  one-cycle result-valid pulse
//   err    engine -> source  one-cycle pulse with done for an invalid mode
//   dout   engine -> source  registered result, held until the next done
// -----------------------------------------------------------------------------
interface shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amt;
    logic [2:0]       mode;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, din, amt, mode,
        input  busy, done, err, dout
    );

    modport slave (
        input  start, din, amt, mode,
        output busy, done, err, dout
    );
endinterface

// File: rtl/shift_engine.sv
// -----------------------------------------------------------------------------
// shift_engine
//   Bit-serial shifter/rotator: LSL, LSR, ASR, ROL, ROR of a WIDTH-bit operand,
//   one bit position per clock, behind a start/busy/done handshake.
//
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  shift_engine_if.slave (start/din/amt/mode in, busy/done/err/dout out)
//
//   Latency: with the acceptance edge as edge 0, done is high in the cycle
//   after edge eff (eff = 0 or an invalid mode: the cycle after edge 0).
// -----------------------------------------------------------------------------
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    shift_engine_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_A   = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       mode_q,  mode_d;
    logic             err_q,   err_d;

    logic             mode_ok;
    logic [AMT_W-1:0] eff;
    logic [WIDTH-1:0] work_step;

    // One bit position of the selected operation.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w,
                                              input logic [2:0]       m);
        case (m)
            MODE_LSL: step = {w[WIDTH-2:0], 1'b0};
            MODE_LSR: step = {1'b0, w[WIDTH-1:1]};
            MODE_ASR: step = {w[WIDTH-1], w[WIDTH-1:1]};
            MODE_ROL: step = {w[WIDTH-2:0], w[WIDTH-1]};
            MODE_ROR: step = {w[0], w[WIDTH-1:1]};
            default:  step = w;
        endcase
    endfunction

    // Effective amount: shifts saturate at WIDTH (everything shifted out),
    // rotates wrap because a full rotation is the identity.
    always_comb begin
        mode_ok = (bus.mode <= MODE_ROR);
        if (bus.mode == MODE_ROL || bus.mode == MODE_ROR) begin
            eff = bus.amt % WIDTH_A;
        end else begin
            eff = (bus.amt > WIDTH_A) ? WIDTH_A : bus.amt;
        end
    end

    assign work_step = step(work_q, mode_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        work_d  = work_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    work_d = bus.din;
                    mode_d = bus.mode;
                    cnt_d  = eff;
                    if (mode_ok && eff != '0) begin
                        state_d = S_SHIFT;
                    end else begin
                        // Nothing to shift (or nothing valid to do): pass through.
                        dout_d  = bus.din;
                        err_d   = ~mode_ok;
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - ONE_A;
                if (cnt_q == ONE_A) begin
                    dout_d  = work_step;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the work register is reset along with the control state so an
    // aborted operation leaves no stale operand behind; it is a single word,
    // not a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.err  = err_q;
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_engine
//   Directed tests for shift_engine (WIDTH=8) plus a randomised run against a
//   whole-word reference model. Inputs change and outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_engine;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_engine_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: whole-word operation with the clamp/wrap rule applied.
    task automatic model(input  logic [7:0] d, input logic [3:0] a, input logic [2:0] m,
                         output logic [7:0] r, output logic e, output int lat);
        int k;
        e = (m > 3'd4);
        if (e) begin
            r   = d;
            lat = 0;
            return;
        end
        if (m == 3'd3 || m == 3'd4) k = int'(a) % 8;
        else                        k = (int'(a) > 8) ? 8 : int'(a);
        case (m)
            3'd0:    r = d << k;
            3'd1:    r = d >> k;
            3'd2:    r = 8'($signed(d) >>> k);
            3'd3:    r = (d << k) | (d >> (8 - k));
            default: r = (d >> k) | (d << (8 - k));
        endcase
        lat = k;
    endtask

    // Launch one operation, follow it to done, then check the idle cycle after.
    task automatic do_op(input string name, input logic [7:0] d, input logic [3:0] a,
                         input logic [2:0] m, input logic [7:0] exp_d,
                         input logic exp_e, input int exp_lat);
        int         lat;
        logic [7:0] prev;
        prev = bus.dout;
        @(negedge clk);
        bus.start = 1'b1; bus.din = d; bus.amt = a; bus.mode = m;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 0; k <= WIDTH + 4; k++) begin
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.dout !== prev) begin
                errors++;
                $display("FAIL %s in-flight cycle %0d: busy=%b err=%b dout=%h, required busy=1 err=0 dout=%h",
                         name, k, bus.busy, bus.err, bus.dout, prev);
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (-1 = no done), required %0d", name, lat, exp_lat);
        end
        if (lat >= 0) begin
            checks++;
            if (bus.dout !== exp_d || bus.err !== exp_e || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s result: dout=%h err=%b busy=%b, required dout=%h err=%b busy=1",
                         name, bus.dout, bus.err, bus.busy, exp_d, exp_e);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.dout !== exp_d) begin
                errors++;
                $display("FAIL %s after done: done=%b busy=%b err=%b dout=%h, required 0 0 0 %h",
                         name, bus.done, bus.busy, bus.err, bus.dout, exp_d);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.din = '0; bus.amt = '0; bus.mode = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset state: busy=%b done=%b err=%b dout=%h, required 0 0 0 00",
                     bus.busy, bus.done, bus.err, bus.dout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_shifts();
        do_op("lsl3", 8'hF0, 4'd3, 3'd0, 8'h80, 1'b0, 3);
        do_op("lsr2", 8'hF0, 4'd2, 3'd1, 8'h3C, 1'b0, 2);
        do_op("asr2", 8'hF0, 4'd2, 3'd2, 8'hFC, 1'b0, 2);
    endtask

    task automatic test_rotates();
        do_op("ror4", 8'hF0, 4'd4, 3'd4, 8'h0F, 1'b0, 4);
        do_op("rol9", 8'hF0, 4'd9, 3'd3, 8'hE1, 1'b0, 1);
        do_op("rol8", 8'hF0, 4'd8, 3'd3, 8'hF0, 1'b0, 0);
        do_op("lsl0", 8'h5A, 4'd0, 3'd0, 8'h5A, 1'b0, 0);
    endtask

    task automatic test_clamp();
        do_op("lsr8",  8'hF0, 4'd8,  3'd1, 8'h00, 1'b0, 8);
        do_op("asr12", 8'hF0, 4'd12, 3'd2, 8'hFF, 1'b0, 8);
        do_op("lsl15", 8'hF0, 4'd15, 3'd0, 8'h00, 1'b0, 8);
        do_op("asr8p", 8'h70, 4'd8,  3'd2, 8'h00, 1'b0, 8);
    endtask

    // LSL 5 of F0 with distracting starts mid-flight, then start held through
    // DONE: the held request must wait for IDLE and be taken one edge later.
    task automatic test_back_to_back();
        logic [7:0] prev;
        prev = bus.dout;
        @(negedge clk);
        bus.start = 1'b1; bus.din = 8'hF0; bus.amt = 4'd5; bus.mode = 3'd0;
        @(negedge clk);
        for (int e = 1; e <= 5; e++) begin
            bus.start = (e == 2 || e == 5);
            bus.din = 8'h0F; bus.mode = 3'd1; bus.amt = 4'd1;
            @(negedge clk);
            if (e < 5) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dout !== prev) begin
                    errors++;
                    $display("FAIL b2b shift cycle %0d: busy=%b done=%b dout=%h, required 1 0 %h",
                             e, bus.busy, bus.done, bus.dout, prev);
                end
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.dout !== 8'h00 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL b2b first result: done=%b dout=%h err=%b, required 1 00 0",
                     bus.done, bus.dout, bus.err);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle gap: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL b2b second accept: busy=%b done=%b dout=%h, required 1 0 00",
                     bus.busy, bus.done, bus.dout);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.dout !== 8'h07 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL b2b second result: done=%b dout=%h err=%b, required 1 07 0",
                     bus.done, bus.dout, bus.err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.din = 8'hF0; bus.amt = 4'd6; bus.mode = 3'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL abort in reset: busy=%b done=%b err=%b dout=%h, required 0 0 0 00",
                     bus.busy, bus.done, bus.err, bus.dout);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.dout !== 8'h00 || bus.busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort after release: activity seen (done/busy/dout nonzero), required all quiet with dout=00");
        end
    endtask

    task automatic test_invalid();
        do_op("inv6", 8'hA5, 4'd3, 3'd6, 8'hA5, 1'b1, 0);
        do_op("inv7", 8'h3C, 4'd0, 3'd7, 8'h3C, 1'b1, 0);
        do_op("inv5", 8'h81, 4'd8, 3'd5, 8'h81, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [7:0] d, r;
        logic [3:0] a;
        logic [2:0] m;
        logic       e;
        int         lat;
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom);
            a = 4'($urandom_range(0, 15));
            m = 3'($urandom_range(0, 7));
            model(d, a, m, r, e, lat);
            do_op($sformatf("rnd%0d", i), d, a, m, r, e, lat);
        end
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_rotates();
        test_clamp();
        test_back_to_back();
        test_reset_abort();
        test_invalid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
- Parametrised sequential successor to the 8-bit combinational shifter.
- Performs one of five shift/rotate operations (LSL, LSR, ASR, ROL, ROR) on a WIDTH-bit operand at one bit per cycle.
- Uses a start/busy/done handshake and holds a registered result.
- Sits between a register-file style operand source and a consumer that waits on done; used where area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- AMT_W, $clog2(WIDTH)+1, shift-amount port width; must allow amt values up to WIDTH.

Ports:
- clk    input   1        rising-edge clock
- rst    input   1        asynchronous, active-high reset
- start  input   1        request; sampled only when busy=0
- din    input   WIDTH    operand, captured on accepted start
- amt    input   AMT_W    shift amount, captured on accepted start
- mode   input   3        0=LSL 1=LSR 2=ASR 3=ROL 4=ROR; 5-7 invalid
- busy   output  1        high from the edge after acceptance until done is issued
- done   output  1        one-cycle pulse; result valid on dout
- err    output  1        one-cycle pulse coincident with done for an invalid mode
- dout   output  WIDTH    registered result; holds until the next done

Behaviour:
- Reset (async, any time): state=IDLE; busy=0, done=0, err=0, dout=0; internal work register and counter cleared.
- Reset mid-operation aborts: no done pulse, and dout stays 0 after release.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - DONE: busy=1, done=1 for exactly one cycle, then returns to IDLE.
- Acceptance: start=1 in IDLE at a rising edge.
  - Capture din into the work register and latch mode.
  - Load counter with the effective amount (eff).
  - eff>0 and mode valid -> SHIFT.
  - eff=0 or mode invalid -> DONE.
- Effective amount:
  - LSL/LSR/ASR: eff = min(amt, WIDTH).
  - ROL/ROR: eff = amt mod WIDTH.
- SHIFT, each edge: shift the work register one bit per mode, then decrement the counter. When the counter goes 1->0, load dout from the shifted value and go to DONE.
- Per-bit ops:
  - LSL: {w[W-2:0],0}
  - LSR: {0,w[W-1:1]}
  - ASR: {w[W-1],w[W-1:1]}
  - ROL: {w[W-2:0],w[W-1]}
  - ROR: {w[0],w[W-1:1]}
- eff=0 or invalid mode: dout <= din on the acceptance edge (pass-through).
- Invalid mode additionally sets err=1 together with done.
- Latency: counting the acceptance edge as edge 0, done is high in the cycle following edge eff (eff=0: cycle after edge 0).
- Back-to-back: start may be asserted during DONE; it is ignored. Earliest re-acceptance is the first IDLE cycle, so there is 1 idle cycle minimum between ops.
- start while busy=1: ignored entirely; captured operands are unaffected by din/amt/mode changes.
- dout changes only on the edge that enters DONE (or on reset); it is stable while busy and after done.
- Shift-out past width: LSL/LSR with eff=WIDTH -> 0; ASR with eff=WIDTH -> all bits = original MSB.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, din=8'hF0:
  - LSL amt=3 -> done after edge 3, dout=8'h80, err=0.
  - LSR amt=2 -> dout=8'h3C.
  - ASR amt=2 -> dout=8'hFC.
- Rotates, din=8'hF0:
  - ROR amt=4 -> 8'h0F after 4 shift edges.
  - ROL amt=9 -> eff=1, dout=8'hE1, done after edge 1.
  - ROL amt=8 -> eff=0, dout=8'hF0, done after edge 0.
- Clamping, din=8'hF0:
  - LSR amt=8 -> 8'h00 after 8 edges.
  - ASR amt=12 -> clamped to 8, dout=8'hFF after 8 edges.
  - LSL amt=15 -> 8'h00 after 8 edges.
- Handshake, din=8'hF0:
  - Start LSL amt=5; pulse start with din=8'h0F, mode=1 at edges 2 and 5 -> ignored; result 8'h00 (from F0).
  - Start asserted through DONE is also ignored; a new op is accepted only in IDLE.
- Reset and invalid mode:
  - Assert rst at edge 3 of an ROR amt=6 op -> busy=0, done never pulses, dout=0.
  - After release, mode=6, din=8'hA5 -> done and err pulse after edge 0, dout=8'hA5.
- Random regression: 1000 random din/amt/mode ops compared against a reference model, checking dout, err, busy and done timing per the latency rule.
